// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises the line, finds the start bit and
// times mid-bit sample strobes for the RX data-collect register.
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_serial,
  input  logic       i_baud_tick,
  input  logic       i_rx_en,
  input  logic       i_parity_en,
  input  logic       i_parity_odd,
  input  logic       i_stop2,
  output logic       o_rx_sync,
  output logic [2:0] o_p_state,
  output logic [2:0] o_index_data,
  output logic       o_count_full,
  output logic       o_rx_done,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    START    = 3'b001,
    RECEIVER = 3'b010,
    PARITY   = 3'b011,
    STOP_I   = 3'b100,
    STOP_II  = 3'b101
  } state_t;

  localparam logic [CNT_W-1:0] HALF_LIMIT = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LIMIT = CNT_W'(OVERSAMPLE - 1);

  state_t           state;
  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;
  logic             count_full;
  logic [2:0]       index;
  logic             par_run;
  logic             cfg_par_en;
  logic             cfg_par_odd;
  logic             cfg_stop2;
  logic             rx_done;
  logic             parity_err;
  logic             frame_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
    end else begin
      sync_meta <= i_rx_serial;
      sync_q    <= sync_meta;
    end
  end

  // Start bit is sampled at its centre, every later bit one full period on.
  assign limit      = (state == START) ? HALF_LIMIT : FULL_LIMIT;
  assign count_full = i_baud_tick && (cnt == limit) && (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      index       <= 3'd0;
      par_run     <= 1'b0;
      cfg_par_en  <= 1'b0;
      cfg_par_odd <= 1'b0;
      cfg_stop2   <= 1'b0;
      rx_done     <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (state == IDLE || count_full) begin
        cnt <= '0;
      end else if (i_baud_tick) begin
        cnt <= cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (i_rx_en && !sync_q) begin
            state       <= START;
            cfg_par_en  <= i_parity_en;
            cfg_par_odd <= i_parity_odd;
            cfg_stop2   <= i_stop2;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            index       <= 3'd0;
            par_run     <= 1'b0;
          end
        end
        START: begin
          if (count_full) begin
            if (!sync_q) begin
              state <= RECEIVER;
              index <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end
        end
        RECEIVER: begin
          if (count_full) begin
            par_run <= par_run ^ sync_q;
            if (index != 3'd7) begin
              index <= index + 3'd1;
            end else begin
              state <= cfg_par_en ? PARITY : STOP_I;
            end
          end
        end
        PARITY: begin
          if (count_full) begin
            parity_err <= (par_run ^ sync_q) != cfg_par_odd;
            state      <= STOP_I;
          end
        end
        STOP_I: begin
          if (count_full) begin
            frame_err <= ~sync_q;
            if (cfg_stop2) begin
              state <= STOP_II;
            end else begin
              state   <= IDLE;
              rx_done <= 1'b1;
            end
          end
        end
        STOP_II: begin
          if (count_full) begin
            frame_err <= frame_err | ~sync_q;
            state     <= IDLE;
            rx_done   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign o_rx_sync    = sync_q;
  assign o_p_state    = state;
  assign o_index_data = index;
  assign o_count_full = count_full;
  assign o_rx_done    = rx_done;
  assign o_parity_err = parity_err;
  assign o_frame_err  = frame_err;
  assign o_busy       = (state != IDLE);

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART RX path. It synchronises the serial line, detects the start bit and times mid-bit sampling from an oversampled baud tick. It drives the state code, bit index and sample strobe that the RX data-collect register uses to assemble the byte, and reports parity/framing status with a one-cycle frame-done pulse.

Parameters:
OVERSAMPLE, 16, baud ticks per bit; even, >=4
CNT_W, 4, width of tick counter; must satisfy 2**CNT_W >= OVERSAMPLE

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_rx_serial  input  1  raw asynchronous RX line, idle high
i_baud_tick  input  1  one-cycle pulse at OVERSAMPLE x baud rate
i_rx_en  input  1  receiver enable
i_parity_en  input  1  parity bit present after data
i_parity_odd  input  1  1 = odd parity, 0 = even
i_stop2  input  1  1 = two stop bits
o_rx_sync  output  1  synchronised RX line; feeds the datapath serial input
o_p_state  output  3  state code: IDLE=000 START=001 RECEIVER=010 PARITY=011 STOP_I=100 STOP_II=101
o_index_data  output  3  data bit index, 0 = LSB
o_count_full  output  1  sample strobe
o_rx_done  output  1  one-cycle frame-complete pulse
o_parity_err  output  1  parity error of the last frame
o_frame_err  output  1  stop-bit error of the last frame
o_busy  output  1  state != IDLE

Behaviour:
- Clock is i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: 2-flop synchroniser = 1 (o_rx_sync = 1). State = IDLE. Tick counter = 0. Index = 0. Running parity = 0. o_rx_done, o_parity_err, o_frame_err = 0. Latched config = 0.
- Reset mid-frame aborts immediately. No o_rx_done is produced. Codes 110/111 are unreachable; if ever reached, next state is IDLE.
- i_rx_serial passes through a 2-flop synchroniser. All decisions use o_rx_sync.
- Tick counter increments on i_baud_tick in non-IDLE states. It clears on every state change.
- Limit = OVERSAMPLE/2-1 in START, OVERSAMPLE-1 in all other states.
- o_count_full = i_baud_tick & (cnt == limit) & state != IDLE. It is combinational from registered state, so the datapath samples on the same edge.
- IDLE: if i_rx_en & o_rx_sync==0 -> START. On this transition: latch i_parity_en, i_parity_odd, i_stop2; clear both error flags, index and running parity. Config changes mid-frame are ignored.
- START, on o_count_full (mid start bit):
  - o_rx_sync==0 -> RECEIVER, index 0.
  - otherwise -> IDLE (glitch rejected; no done, errors stay 0).
- RECEIVER, on o_count_full: running parity ^= o_rx_sync.
  - index < 7: index +1.
  - index == 7: -> PARITY if parity enabled, else STOP_I. Index stays 7.
- PARITY, on o_count_full: o_parity_err = (running parity ^ o_rx_sync) != parity_odd. Then -> STOP_I.
- STOP_I, on o_count_full: o_frame_err = ~o_rx_sync.
  - stop2: -> STOP_II.
  - otherwise: -> IDLE.
- STOP_II, on o_count_full: o_frame_err |= ~o_rx_sync. Then -> IDLE.
- o_rx_done: registered. High the cycle after the final stop-bit o_count_full, coincident with state = IDLE. Errors are valid when o_rx_done is high and hold until the next START entry.
- A new start bit can be accepted the cycle o_rx_done is high; back-to-back frames need no gap.
- i_rx_en deasserting mid-frame has no effect; the frame completes. It only blocks leaving IDLE.
- i_baud_tick during IDLE is ignored. The counter only runs outside IDLE.

Test Plan:
1. OVERSAMPLE=16, tick every cycle, 8N1 frame 0xA5.
   - START count_full at tick 7 after START entry; data strobes every 16 ticks, index 0..7.
   - Exactly one o_rx_done; datapath byte = 0xA5; both errors 0.
2. Line low for 4 ticks, then high.
   - START -> IDLE at the mid-start strobe; no o_rx_done; o_busy drops.
3. Even parity, byte 0x3C:
   - parity bit 0 -> o_parity_err 0.
   - repeat with parity bit 1 -> o_parity_err 1.
   - odd parity with bit 1 -> o_parity_err 0.
4. Framing, byte 0x81:
   - stop bit driven 0 -> o_frame_err 1.
   - i_stop2=1 with first stop 1 and second stop 0 -> o_frame_err 1, o_rx_done after STOP_II.
5. Reset pulse in RECEIVER at index 4:
   - all outputs return to reset values asynchronously; no done.
   - next frame 0x55 is received correctly, errors 0.
6. i_baud_tick every 3rd cycle, back-to-back 0x12, 0x34:
   - o_count_full high only on tick cycles.
   - two o_rx_done pulses; bytes 0x12, 0x34.
   - toggling i_parity_en mid-frame has no effect.
